// File: rtl/iic_pkg.sv
// Shared types for the I2C byte engine: command codes, FSM states, bit phases.
// Pure declarations; no logic of its own.
package iic_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Eight data bits plus the ACK/NACK slot.
  localparam int BITS_PER_BYTE = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_e;

  typedef enum logic [1:0] {
    PH0,
    PH1,
    PH2,
    PH3
  } phase_e;

  typedef struct packed {
    logic scl;
    logic sda_o;
    logic sda_oe;
  } bus_t;

  function automatic phase_e next_phase(input phase_e p);
    logic [1:0] n;
    n = p + 2'd1;
    return phase_e'(n);
  endfunction

endpackage

// File: rtl/iic_phase_timer.sv
// Quarter-bit timer: each phase lasts div+1 cycles, phase index wraps PH3->PH0.
// No handshake; counts only while run is high, restarts on clear.
module iic_phase_timer
  import iic_pkg::*;
(
  input  logic        clk,
  input  logic        iic_rst,
  input  logic        clear,
  input  logic        run,
  input  logic [15:0] div,
  output logic        phase_last,
  output phase_e      phase
);

  logic [15:0] cnt_q;
  phase_e      ph_q;

  // Compare against div rather than div+1 so 16'hFFFF never wraps the counter.
  assign phase_last = run && (cnt_q == div);
  assign phase      = ph_q;

  always_ff @(posedge clk) begin
    if (iic_rst || clear) begin
      cnt_q <= '0;
      ph_q  <= PH0;
    end else if (run) begin
      if (phase_last) begin
        cnt_q <= '0;
        ph_q  <= next_phase(ph_q);
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/iic_byte_engine.sv
// I2C bit/byte engine: START/STOP take 4N cycles, WRITE/READ 36N (N = clk_div+1), done pulse after.
// One command at a time; cmd_ready only in IDLE with iic_en, a command in flight always completes.
module iic_byte_engine
  import iic_pkg::*;
(
  input  logic        clk,
  input  logic        iic_rst,
  input  logic        iic_en,
  input  logic [15:0] clk_div,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  input  logic [7:0]  cmd_wdata,
  input  logic        cmd_nack,
  input  logic        iic_sda_i,
  output logic        iic_sda_o,
  output logic        iic_sda_out,
  output logic        iic_scl,
  output logic [7:0]  rec_data,
  output logic        iic_ack,
  output logic        iic_busy,
  output logic        iic_done
);

  state_e      state_q, state_d;
  phase_e      phase, phase_d;
  logic        phase_last;
  logic [15:0] div_q, div_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  rec_q, rec_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        nack_q, nack_d;
  logic        samp_q, samp_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  bus_t        bus_q, bus_d;

  logic accept, run, bit_end, smp_pt, last_bit;

  assign run       = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && iic_en && !iic_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign bit_end   = phase_last && (phase == PH3);
  assign smp_pt    = phase_last && (phase == PH2);
  assign last_bit  = (bitcnt_q == 4'(BITS_PER_BYTE - 1));

  iic_phase_timer u_timer (
    .clk        (clk),
    .iic_rst    (iic_rst),
    .clear      (accept),
    .run        (run),
    .div        (div_q),
    .phase_last (phase_last),
    .phase      (phase)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sr_d     = sr_q;
    rec_d    = rec_q;
    bitcnt_d = bitcnt_q;
    nack_d   = nack_q;
    samp_d   = samp_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    phase_d  = phase;
    bus_d    = bus_q;

    if (accept) begin
      phase_d = PH0;
    end else if (phase_last) begin
      phase_d = next_phase(phase);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_d = ST_START;
            CMD_STOP:  state_d = ST_STOP;
            CMD_WRITE: state_d = ST_WRITE;
            default:   state_d = ST_READ;
          endcase
          div_d    = clk_div;
          sr_d     = cmd_wdata;
          nack_d   = cmd_nack;
          bitcnt_d = '0;
        end
      end
      ST_START, ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WRITE, ST_READ: begin
        if (smp_pt) begin
          samp_d = iic_sda_i;
          if (state_q == ST_READ && !last_bit) begin
            sr_d = {sr_q[6:0], iic_sda_i};
          end
        end
        if (bit_end) begin
          if (last_bit) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (state_q == ST_WRITE) begin
              ack_d = ~samp_q;
            end else begin
              rec_d = sr_q;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (state_q == ST_WRITE) begin
              sr_d = {sr_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from the state/phase being entered, so they change
    // exactly at phase boundaries; IDLE simply holds the last bus levels.
    case (state_d)
      ST_START: begin
        case (phase_d)
          PH0: begin
            bus_d.sda_o  = 1'b1;
            bus_d.sda_oe = 1'b0;
          end
          PH1: begin
            bus_d.scl    = 1'b1;
            bus_d.sda_o  = 1'b1;
            bus_d.sda_oe = 1'b0;
          end
          PH2: begin
            bus_d.scl    = 1'b1;
            bus_d.sda_o  = 1'b0;
            bus_d.sda_oe = 1'b1;
          end
          default: begin
            bus_d.scl    = 1'b0;
            bus_d.sda_o  = 1'b0;
            bus_d.sda_oe = 1'b1;
          end
        endcase
      end
      ST_STOP: begin
        bus_d.scl    = (phase_d != PH0);
        bus_d.sda_o  = (phase_d == PH2) || (phase_d == PH3);
        bus_d.sda_oe = (phase_d == PH0) || (phase_d == PH1);
      end
      ST_WRITE, ST_READ: begin
        bus_d.scl = (phase_d == PH1) || (phase_d == PH2);
        if (bitcnt_d == 4'(BITS_PER_BYTE - 1)) begin
          bus_d.sda_o  = (state_d == ST_READ) ? nack_d : 1'b1;
          bus_d.sda_oe = (state_d == ST_READ);
        end else if (state_d == ST_WRITE) begin
          bus_d.sda_o  = sr_d[7];
          bus_d.sda_oe = ~sr_d[7];
        end else begin
          bus_d.sda_o  = 1'b1;
          bus_d.sda_oe = 1'b0;
        end
      end
      default: bus_d = bus_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iic_rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      sr_q         <= '0;
      rec_q        <= '0;
      bitcnt_q     <= '0;
      nack_q       <= 1'b0;
      samp_q       <= 1'b1;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      bus_q.scl    <= 1'b1;
      bus_q.sda_o  <= 1'b1;
      bus_q.sda_oe <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sr_q     <= sr_d;
      rec_q    <= rec_d;
      bitcnt_q <= bitcnt_d;
      nack_q   <= nack_d;
      samp_q   <= samp_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      bus_q    <= bus_d;
    end
  end

  assign iic_scl     = bus_q.scl;
  assign iic_sda_o   = bus_q.sda_o;
  assign iic_sda_out = bus_q.sda_oe;
  assign rec_data    = rec_q;
  assign iic_ack     = ack_q;
  assign iic_busy    = run;
  assign iic_done    = done_q;

endmodule

// File: tb/tb_iic_byte_engine.sv
// Directed bench for iic_byte_engine: issued commands push expected results,
// a monitor checks them on every iic_done; a small slave model drives SDA.
module tb_iic_byte_engine;
  import iic_pkg::*;

  logic        clk = 1'b0;
  logic        iic_rst = 1'b1;
  logic        iic_en = 1'b1;
  logic [15:0] clk_div = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_nack = 1'b0;
  logic        cmd_ready, iic_sda_o, iic_sda_out, iic_scl, iic_ack, iic_busy, iic_done;
  logic [7:0]  rec_data;
  logic        sda_bus;

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [7:0] rec;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   falls = 0;
  logic scl_prev = 1'b1;
  logic rise_q[$];

  int         slave_mode = 0;
  int         fall_base = 0;
  logic [7:0] slave_byte = '0;
  logic       slave_ack = 1'b0;
  logic [7:0] m_rec = '0;
  logic       m_ack = 1'b0;

  function automatic logic slave_pull(input int mode, input int k, input logic [7:0] b, input logic a);
    logic [7:0] bb;
    bb = b;
    if (mode == 2 && k >= 0 && k < 8) return !bb[7-k];
    if (mode == 1 && k == 8) return a;
    return 1'b0;
  endfunction

  always_comb sda_bus = !((iic_sda_out && !iic_sda_o) ||
                          slave_pull(slave_mode, falls - fall_base, slave_byte, slave_ack));

  iic_byte_engine dut (
    .clk         (clk),
    .iic_rst     (iic_rst),
    .iic_en      (iic_en),
    .clk_div     (clk_div),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .cmd_wdata   (cmd_wdata),
    .cmd_nack    (cmd_nack),
    .iic_sda_i   (sda_bus),
    .iic_sda_o   (iic_sda_o),
    .iic_sda_out (iic_sda_out),
    .iic_scl     (iic_scl),
    .rec_data    (rec_data),
    .iic_ack     (iic_ack),
    .iic_busy    (iic_busy),
    .iic_done    (iic_done)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    scl_prev <= iic_scl;
    if (scl_prev && !iic_scl) falls <= falls + 1;
    if (!scl_prev && iic_scl) rise_q.push_back(sda_bus);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (iic_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_done", iic_done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chki("latency", cyc - acc_cyc, e.lat);
          chk8("rec_data", rec_data, e.rec);
          chk1("iic_ack", iic_ack, e.ack);
          chk1("busy_at_done", iic_busy, 1'b0);
          chk1("ready_at_done", cmd_ready, iic_en);
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                       input logic [15:0] dv, input bit push);
    exp_t e;
    @(negedge clk);
    cmd = c; cmd_wdata = wd; cmd_nack = nk; clk_div = dv; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    chk1("cmd_accept", cmd_ready, 1'b1);
    if (push) begin
      e.lat = (c[1] ? 36 : 4) * (int'(dv) + 1);
      e.rec = m_rec;
      e.ack = m_ack;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10000 && exp_q.size() != 0; i++) @(negedge clk);
    chki("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_scl, exp_sda, got;
    int rb;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk1("rst_scl", iic_scl, 1'b1);
    chk1("rst_sda_o", iic_sda_o, 1'b1);
    chk1("rst_sda_out", iic_sda_out, 1'b0);
    chk8("rst_rec", rec_data, 8'h00);
    chk1("rst_ack", iic_ack, 1'b0);
    chk1("rst_busy", iic_busy, 1'b0);
    chk1("rst_done", iic_done, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b0);
    iic_rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_rst", cmd_ready, 1'b1);

    // Disabled engine ignores an offered command.
    iic_en = 1'b0; cmd = CMD_START; cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1("dis_ready", cmd_ready, 1'b0);
      chk1("dis_scl", iic_scl, 1'b1);
    end
    cmd_valid = 1'b0; iic_en = 1'b1;

    // START, clk_div=1: waveform per cycle after accept (bit k = cycle k).
    exp_scl = 8'b0011_1111;
    exp_sda = 8'b0000_1111;
    issue(CMD_START, 8'h00, 1'b0, 16'd1, 1'b1);
    chk1("start_busy", iic_busy, 1'b1);
    chk1("start_ready", cmd_ready, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk1("start_scl", iic_scl, exp_scl[k]);
      chk1("start_sda", sda_bus, exp_sda[k]);
    end
    drain();

    // WRITE A5 with slave ACK.
    m_ack = 1'b1; slave_mode = 1; slave_ack = 1'b1; fall_base = falls; rb = rise_q.size();
    issue(CMD_WRITE, 8'hA5, 1'b0, 16'd1, 1'b1);
    drain();
    chki("wr_rises", rise_q.size() - rb, 9);
    got = '0;
    for (int i = 0; i < 8; i++) got[7-i] = rise_q[rb+i];
    chk8("wr_bits", got, 8'hA5);
    chk1("wr_ack_slot", rise_q[rb+8], 1'b0);

    // WRITE 5A with slave NACK, clk_div=0.
    m_ack = 1'b0; slave_ack = 1'b0; fall_base = falls;
    issue(CMD_WRITE, 8'h5A, 1'b0, 16'd0, 1'b1);
    drain();

    // READ 3C with NACK, clk_div=2.
    slave_mode = 2; slave_byte = 8'h3C; m_rec = 8'h3C; fall_base = falls;
    issue(CMD_READ, 8'h00, 1'b1, 16'd2, 1'b1);
    drain();
    chk1("rd_nack_oe", iic_sda_out, 1'b1);
    chk1("rd_nack_val", iic_sda_o, 1'b1);

    // READ 81 with ACK leaves SDA driven low, SCL low.
    slave_byte = 8'h81; m_rec = 8'h81; fall_base = falls;
    issue(CMD_READ, 8'h00, 1'b0, 16'd0, 1'b1);
    drain();
    chk1("rd_ack_oe", iic_sda_out, 1'b1);
    chk1("rd_ack_val", iic_sda_o, 1'b0);
    slave_mode = 0;

    // Repeated START from SCL low: SDA released before SCL rises.
    issue(CMD_START, 8'h00, 1'b0, 16'd1, 1'b1);
    chk1("rs_c0_scl", iic_scl, 1'b0);
    chk1("rs_c0_oe", iic_sda_out, 1'b0);
    repeat (2) @(negedge clk);
    chk1("rs_c2_scl", iic_scl, 1'b1);
    chk1("rs_c2_sda", sda_bus, 1'b1);
    drain();

    // STOP, clk_div=1.
    issue(CMD_STOP, 8'h00, 1'b0, 16'd1, 1'b1);
    chk1("sp_c0_scl", iic_scl, 1'b0);
    chk1("sp_c0_sda", sda_bus, 1'b0);
    repeat (2) @(negedge clk);
    chk1("sp_c2_scl", iic_scl, 1'b1);
    chk1("sp_c2_sda", sda_bus, 1'b0);
    repeat (2) @(negedge clk);
    chk1("sp_c4_sda", sda_bus, 1'b1);
    drain();
    chk1("sp_end_scl", iic_scl, 1'b1);
    chk1("sp_end_oe", iic_sda_out, 1'b0);
    chk1("sp_end_busy", iic_busy, 1'b0);

    // Back-to-back STOP.
    issue(CMD_STOP, 8'h00, 1'b0, 16'd0, 1'b1);
    drain();

    // iic_en dropped mid-READ: transfer still completes.
    issue(CMD_START, 8'h00, 1'b0, 16'd0, 1'b1);
    drain();
    slave_mode = 2; slave_byte = 8'hC3; m_rec = 8'hC3; fall_base = falls;
    issue(CMD_READ, 8'h00, 1'b0, 16'd0, 1'b1);
    repeat (10) @(negedge clk);
    iic_en = 1'b0;
    drain();
    chk1("en_low_ready", cmd_ready, 1'b0);
    iic_en = 1'b1;
    slave_mode = 0;

    // Reset during WRITE (clk_div=0) at cycle 20: no done, bus released.
    issue(CMD_WRITE, 8'hFF, 1'b0, 16'd0, 1'b0);
    repeat (20) @(negedge clk);
    chk1("pre_rst_busy", iic_busy, 1'b1);
    iic_rst = 1'b1;
    @(negedge clk);
    chk1("mrst_scl", iic_scl, 1'b1);
    chk1("mrst_sda_out", iic_sda_out, 1'b0);
    chk1("mrst_busy", iic_busy, 1'b0);
    chk1("mrst_done", iic_done, 1'b0);
    chk8("mrst_rec", rec_data, 8'h00);
    m_rec = 8'h00; m_ack = 1'b0;
    iic_rst = 1'b0;
    repeat (40) @(negedge clk);
    chk1("post_rst_busy", iic_busy, 1'b0);

    issue(CMD_START, 8'h00, 1'b0, 16'd0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
